// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the clock-generator configuration controller.
package clk_gen_pkg;

  localparam int unsigned MEM_SIZE_DEF = 32;
  localparam int unsigned HP_BASE_DEF  = 3;
  localparam int unsigned TIMEOUT_MULT = 2;

  typedef enum logic [1:0] {
    OP_READ     = 2'b00,
    OP_WRITE    = 2'b01,
    OP_FREEZE   = 2'b10,
    OP_UNFREEZE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FALL,
    APPLY,
    RESP
  } state_e;

endpackage

// File: rtl/clk_gen_fall_wait.sv
// Falling-edge detector on the selected generated clock plus tick-driven timeout.
module clk_gen_fall_wait
  import clk_gen_pkg::*;
#(
  parameter int unsigned CLOCK_NUMBER = 9,
  parameter int unsigned MEM_SIZE     = MEM_SIZE_DEF,
  parameter int unsigned IDX_W        = $clog2(CLOCK_NUMBER)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    tick_i,
  input  logic [CLOCK_NUMBER-1:0] clk_state_i,
  input  logic [IDX_W-1:0]        idx_i,
  output logic                    fall_o,
  output logic                    timeout_o
);

  localparam int unsigned LIMIT = TIMEOUT_MULT * MEM_SIZE;
  localparam int unsigned CNT_W = $clog2(LIMIT + 1);
  localparam int unsigned SEL_N = 2 ** IDX_W;

  logic [CLOCK_NUMBER-1:0] r_state_q;
  logic [CNT_W-1:0]        r_cnt;
  logic [SEL_N-1:0]        w_cur;
  logic [SEL_N-1:0]        w_prev;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state_q <= '0;
    else         r_state_q <= clk_state_i;
  end

  // Zero-padded to the full index range so any idx value selects safely.
  assign w_cur  = SEL_N'(clk_state_i);
  assign w_prev = SEL_N'(r_state_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                       r_cnt <= '0;
    else if (clr_i)                                    r_cnt <= '0;
    else if (en_i && tick_i && r_cnt != CNT_W'(LIMIT)) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign fall_o    = en_i & w_prev[idx_i] & ~w_cur[idx_i];
  assign timeout_o = en_i & tick_i & (r_cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/clk_gen_cfg_ctrl.sv
// Half-period table and freeze flag for the multi-clock scheduler; writes land
// just after the target clock's falling edge so no runt phase is generated.
module clk_gen_cfg_ctrl
  import clk_gen_pkg::*;
#(
  parameter int unsigned CLOCK_NUMBER = 9,
  parameter int unsigned MEM_SIZE     = MEM_SIZE_DEF,
  parameter int unsigned HP_BASE      = HP_BASE_DEF,
  parameter int unsigned HP_W         = $clog2(MEM_SIZE),
  parameter int unsigned IDX_W        = $clog2(CLOCK_NUMBER)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_op_i,
  input  logic [IDX_W-1:0]             req_idx_i,
  input  logic [HP_W-1:0]              req_hp_i,
  output logic                         rsp_valid_o,
  output logic                         rsp_err_o,
  output logic [HP_W-1:0]              rsp_hp_o,
  input  logic                         tick_i,
  input  logic [CLOCK_NUMBER-1:0]      clk_state_i,
  output logic [CLOCK_NUMBER*HP_W-1:0] clk_hp_o,
  output logic                         freeze_o
);

  state_e           r_state, w_state_nxt;
  op_e              r_op, w_op_in;
  logic [IDX_W-1:0] r_idx;
  logic [HP_W-1:0]  r_hp_new;
  logic             r_err, r_ready, r_freeze;
  logic [HP_W-1:0]  r_tab [CLOCK_NUMBER];
  logic             w_accept, w_idx_ok, w_err_acc, w_fall, w_timeout;
  logic [HP_W-1:0]  w_entry;

  assign w_op_in  = op_e'(req_op_i);
  assign w_accept = req_valid_i & r_ready & (r_state == IDLE);
  assign w_idx_ok = 32'(req_idx_i) < CLOCK_NUMBER;

  clk_gen_fall_wait #(
    .CLOCK_NUMBER (CLOCK_NUMBER),
    .MEM_SIZE     (MEM_SIZE),
    .IDX_W        (IDX_W)
  ) u_fall_wait (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (w_accept),
    .en_i        (r_state == WAIT_FALL),
    .tick_i      (tick_i),
    .clk_state_i (clk_state_i),
    .idx_i       (r_idx),
    .fall_o      (w_fall),
    .timeout_o   (w_timeout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err_acc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (w_op_in)
            OP_READ: begin
              w_state_nxt = RESP;
              w_err_acc   = ~w_idx_ok;
            end
            OP_WRITE: begin
              if (!w_idx_ok || req_hp_i == '0) begin
                w_state_nxt = RESP;
                w_err_acc   = 1'b1;
              end else if (r_freeze) begin
                w_state_nxt = APPLY;
              end else begin
                w_state_nxt = WAIT_FALL;
              end
            end
            default: w_state_nxt = RESP;
          endcase
        end
      end
      // A fall coinciding with the final tick takes priority over the timeout.
      WAIT_FALL: begin
        if (w_fall)         w_state_nxt = APPLY;
        else if (w_timeout) w_state_nxt = RESP;
      end
      APPLY:   w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_op     <= OP_READ;
      r_idx    <= '0;
      r_hp_new <= '0;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
      r_freeze <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_op     <= w_op_in;
        r_idx    <= req_idx_i;
        r_hp_new <= req_hp_i;
        r_err    <= w_err_acc;
        if (w_op_in == OP_FREEZE)        r_freeze <= 1'b1;
        else if (w_op_in == OP_UNFREEZE) r_freeze <= 1'b0;
      end else if (r_state == WAIT_FALL && w_state_nxt == RESP) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < CLOCK_NUMBER; k++) r_tab[k] <= HP_W'(HP_BASE + k);
    end else if (r_state == APPLY) begin
      for (int unsigned k = 0; k < CLOCK_NUMBER; k++)
        if (32'(r_idx) == k) r_tab[k] <= r_hp_new;
    end
  end

  always_comb begin
    w_entry  = '0;
    clk_hp_o = '0;
    for (int unsigned k = 0; k < CLOCK_NUMBER; k++) begin
      clk_hp_o[k*HP_W +: HP_W] = r_tab[k];
      if (32'(r_idx) == k) w_entry = r_tab[k];
    end
  end

  assign req_ready_o = r_ready;
  assign freeze_o    = r_freeze;
  assign rsp_valid_o = (r_state == RESP);
  assign rsp_err_o   = rsp_valid_o & r_err;
  assign rsp_hp_o    = (rsp_valid_o && (r_op == OP_READ || r_op == OP_WRITE)) ? w_entry : '0;

endmodule
